// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: tick prescalers, button conditioning, RUN/PAUSED/ADJUST FSM
// and the BCD mm:ss time registers consumed by the display block.
module stopwatch_ctrl #(
    parameter int TICK_1HZ  = 100_000_000,
    parameter int TICK_ADJ  = 50_000_000,
    parameter int TICK_DIS  = 100_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       adj,
    input  logic       sel,
    output logic [2:0] m10,
    output logic [3:0] m1,
    output logic [2:0] s10,
    output logic [3:0] s1,
    output logic       dis_en,
    output logic       blink,
    output logic       running
);

    localparam int W1 = (TICK_1HZ  > 1) ? $clog2(TICK_1HZ)  : 1;
    localparam int WA = (TICK_ADJ  > 1) ? $clog2(TICK_ADJ)  : 1;
    localparam int WS = (TICK_DIS  > 1) ? $clog2(TICK_DIS)  : 1;
    localparam int WD = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN,
        PAUSED,
        ADJUST
    } state_t;

    state_t state;

    logic          adj_m, adj_s, sel_m, sel_s;
    logic [1:0]    btn_m, btn_s;        // bit 0 = pause, bit 1 = clear
    logic [1:0]    btn_lvl, btn_lvl_d, btn_p;
    logic [WD-1:0] db_cnt [2];
    logic          pause_p, clr_p;

    logic [W1-1:0] hz_cnt;
    logic [WA-1:0] adj_cnt;
    logic [WS-1:0] dis_cnt;
    logic          run_tick, adj_tick, sec_wrap;

    // Increment a BCD pair modulo 60; out-of-range digits fall back to legal values.
    function automatic logic [6:0] inc60(input logic [2:0] tens, input logic [3:0] ones);
        logic [2:0] t;
        logic [3:0] o;
        if (ones >= 4'd9) begin
            o = 4'd0;
            t = (tens >= 3'd5) ? 3'd0 : tens + 3'd1;
        end else begin
            o = ones + 4'd1;
            t = (tens > 3'd5) ? 3'd0 : tens;
        end
        return {t, o};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            adj_m <= 1'b0;
            adj_s <= 1'b0;
            sel_m <= 1'b0;
            sel_s <= 1'b0;
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            adj_m <= adj;
            adj_s <= adj_m;
            sel_m <= sel;
            sel_s <= sel_m;
            btn_m <= {btn_clr, btn_pause};
            btn_s <= btn_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
            btn_lvl   <= '0;
            btn_lvl_d <= '0;
            btn_p     <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (btn_s[i] == btn_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == WD'(DB_CYCLES - 1)) begin
                    btn_lvl[i] <= btn_s[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + WD'(1);
                end
            end
            btn_lvl_d <= btn_lvl;
            btn_p     <= btn_lvl & ~btn_lvl_d;
        end
    end

    assign pause_p = btn_p[0];
    assign clr_p   = btn_p[1];

    always_comb begin
        run_tick = (state == RUN)    && (hz_cnt  == W1'(TICK_1HZ - 1));
        adj_tick = (state == ADJUST) && (adj_cnt == WA'(TICK_ADJ - 1));
        sec_wrap = (s1 == 4'd9) && (s10 == 3'd5);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dis_cnt <= '0;
            dis_en  <= 1'b0;
        end else if (dis_cnt == WS'(TICK_DIS - 1)) begin
            dis_cnt <= '0;
            dis_en  <= 1'b1;
        end else begin
            dis_cnt <= dis_cnt + WS'(1);
            dis_en  <= 1'b0;
        end
    end

    // The 1 Hz prescaler only holds outside RUN so a resumed second keeps its elapsed part.
    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            hz_cnt <= '0;
        end else if (state == RUN) begin
            if (run_tick) hz_cnt <= '0;
            else          hz_cnt <= hz_cnt + W1'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != ADJUST)) begin
            adj_cnt <= '0;
        end else if (adj_tick) begin
            adj_cnt <= '0;
        end else begin
            adj_cnt <= adj_cnt + WA'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            running <= 1'b1;
            blink   <= 1'b0;
        end else if (adj_s) begin
            state   <= ADJUST;
            running <= 1'b0;
            if (adj_tick) blink <= ~blink;
        end else begin
            case (state)
                RUN: begin
                    if (pause_p) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (pause_p) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= PAUSED;
                    running <= 1'b0;
                    blink   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_p) begin
            m10 <= '0;
            m1  <= '0;
            s10 <= '0;
            s1  <= '0;
        end else if (run_tick) begin
            {s10, s1} <= inc60(s10, s1);
            if (sec_wrap) {m10, m1} <= inc60(m10, m1);
        end else if (adj_tick) begin
            if (sel_s) {s10, s1} <= inc60(s10, s1);
            else       {m10, m1} <= inc60(m10, m1);
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small tick/debounce parameters;
// time is checked as a packed BCD word 0mmm_mmmm_0sss_ssss (reads as hex mm:ss).
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_pause;
    logic       btn_clr;
    logic       adj;
    logic       sel;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [2:0] s10;
    logic [3:0] s1;
    logic       dis_en;
    logic       blink;
    logic       running;
    logic [15:0] tnow;

    int vectors = 0;
    int miscompares = 0;

    stopwatch_ctrl #(
        .TICK_1HZ (10),
        .TICK_ADJ (4),
        .TICK_DIS (3),
        .DB_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_pause(btn_pause),
        .btn_clr  (btn_clr),
        .adj      (adj),
        .sel      (sel),
        .m10      (m10),
        .m1       (m1),
        .s10      (s10),
        .s1       (s1),
        .dis_en   (dis_en),
        .blink    (blink),
        .running  (running)
    );

    assign tnow = {1'b0, m10, m1, 1'b0, s10, s1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; btn_pause = 1'b0; btn_clr = 1'b0; adj = 1'b0; sel = 1'b0;
        step(3);
        chk("rst_time", tnow, 16'h0000);
        chk("rst_dis_en", 16'(dis_en), 16'h0);
        chk("rst_blink", 16'(blink), 16'h0);
        chk("rst_running", 16'(running), 16'h1);

        // Count from reset: first tick 10 cycles after release, dis_en every 3rd cycle
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("dis_en_phase", 16'(dis_en), 16'(k % 3 == 0));
        end
        chk("pre_first_tick", tnow, 16'h0000);
        step(1);     chk("first_tick", tnow, 16'h0001);
        step(580);   chk("t590", tnow, 16'h0059);
        step(10);    chk("t600_min_carry", tnow, 16'h0100);
        step(5399);  chk("t5999", tnow, 16'h0959);
        step(1);     chk("t6000_m10_carry", tnow, 16'h1000);
        step(29980); chk("t5958", tnow, 16'h5958);
        step(10);    chk("t5959", tnow, 16'h5959);
        step(10);    chk("wrap_to_0000", tnow, 16'h0000);

        // Clean pause press: pulse 7 cycles after the rise, state changes the cycle after
        btn_pause = 1'b1;
        step(6); chk("pause_r6_run", 16'(running), 16'h1);
        step(1); chk("pause_r7_run", 16'(running), 16'h1);
        step(1); chk("pause_r8_paused", 16'(running), 16'h0);
        chk("pause_r8_time", tnow, 16'h0000);
        step(50); chk("pause_hold_run", 16'(running), 16'h0);
        chk("pause_frozen", tnow, 16'h0000);
        btn_pause = 1'b0;
        step(20); chk("pause_release_run", 16'(running), 16'h0);
        chk("pause_release_time", tnow, 16'h0000);
        btn_pause = 1'b1;
        step(8); chk("resume_running", 16'(running), 16'h1);
        chk("resume_time", tnow, 16'h0000);
        step(1); chk("resume_plus1", tnow, 16'h0000);
        step(1); chk("resume_partial_second", tnow, 16'h0001);
        btn_pause = 1'b0;

        // Clear button glitches shorter than the debounce window are rejected
        for (int g = 0; g < 3; g++) begin
            btn_clr = 1'b1; step(3);
            btn_clr = 1'b0; step(5);
        end
        chk("glitch_no_clear", tnow, 16'h0003);
        chk("glitch_running", 16'(running), 16'h1);
        step(7506); chk("t1234", tnow, 16'h1234);
        btn_clr = 1'b1;
        step(7); chk("clr_before_pulse", tnow, 16'h1234);
        step(1); chk("clr_applied", tnow, 16'h0000);
        chk("clr_state_kept", 16'(running), 16'h1);
        step(9); chk("clr_prescaler_reset", tnow, 16'h0000);
        step(1); chk("clr_first_tick", tnow, 16'h0001);
        btn_clr = 1'b0;
        step(12); chk("pre_align", tnow, 16'h0002);
        btn_clr = 1'b1;
        step(7); chk("align_before", tnow, 16'h0002);
        step(1); chk("clr_beats_tick", tnow, 16'h0000);
        btn_clr = 1'b0;
        step(10); chk("after_align_tick", tnow, 16'h0001);

        // Adjust seconds from 00:58
        step(570); chk("t0058", tnow, 16'h0058);
        adj = 1'b1; sel = 1'b1;
        step(2); chk("adj_sync_run", 16'(running), 16'h1);
        step(1); chk("adj_entry_run", 16'(running), 16'h0);
        step(3); chk("adj_pre_step", tnow, 16'h0058);
        chk("adj_pre_blink", 16'(blink), 16'h0);
        step(1); chk("adj_sec_59", tnow, 16'h0059);
        chk("adj_blink_1", 16'(blink), 16'h1);
        step(4); chk("adj_sec_wrap_no_carry", tnow, 16'h0000);
        chk("adj_blink_0", 16'(blink), 16'h0);
        btn_pause = 1'b1; step(6);
        btn_pause = 1'b0; step(6);
        chk("adj_pause_ignored_time", tnow, 16'h0003);
        chk("adj_pause_ignored_blink", 16'(blink), 16'h1);
        chk("adj_pause_ignored_run", 16'(running), 16'h0);
        step(28); chk("adj_sec_10", tnow, 16'h0010);

        // Adjust minutes to 59 and across the wrap
        sel = 1'b0;
        step(36);  chk("adj_min_09", tnow, 16'h0910);
        step(4);   chk("adj_min_10", tnow, 16'h1010);
        step(196); chk("adj_min_59", tnow, 16'h5910);
        chk("adj_min_59_blink", 16'(blink), 16'h1);
        step(4);   chk("adj_min_wrap", tnow, 16'h0010);
        chk("adj_min_wrap_blink", 16'(blink), 16'h0);
        step(2);
        adj = 1'b0;
        step(2); chk("adj_exit_last_step", tnow, 16'h0110);
        chk("adj_exit_last_blink", 16'(blink), 16'h1);
        step(1); chk("paused_blink", 16'(blink), 16'h0);
        chk("paused_running", 16'(running), 16'h0);
        step(20); chk("paused_frozen", tnow, 16'h0110);

        // Re-enter ADJUST, set 23:45, then reset mid-adjust
        adj = 1'b1;
        step(3);   chk("adj2_entry_blink", 16'(blink), 16'h0);
        step(88);  chk("adj2_min_23", tnow, 16'h2310);
        sel = 1'b1;
        step(140); chk("adj2_2345", tnow, 16'h2345);
        chk("adj2_blink", 16'(blink), 16'h1);
        step(1);
        rst = 1'b1; adj = 1'b0; sel = 1'b0;
        step(1);
        chk("mid_rst_time", tnow, 16'h0000);
        chk("mid_rst_running", 16'(running), 16'h1);
        chk("mid_rst_blink", 16'(blink), 16'h0);
        chk("mid_rst_dis_en", 16'(dis_en), 16'h0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("post_rst_dis_en", 16'(dis_en), 16'(k % 3 == 0));
        end
        chk("post_rst_running", 16'(running), 16'h1);
        step(4); chk("post_rst_first_tick", tnow, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
